// File: rtl/tinyalu_arbiter.sv
// rtl/tinyalu_arbiter.sv - round-robin scheduler sharing one TinyALU between NUM_REQ requesters
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   req_valid / req_ready   per-requester command handshake (ready is a one-hot accept pulse)
//   req_A / req_B / req_op  per-requester command slices (8/8/3 bits per requester)
//   rsp_valid               one-hot response pulse toward the originating requester
//   rsp_result / rsp_err    response payload, held between responses
//   alu_A/alu_B/alu_op      registered command bus toward the ALU
//   alu_start / alu_done    ALU handshake (start held until done or abort)
//   alu_result              ALU result, captured when done is sampled
//   busy                    high whenever a command is in flight or responding
module tinyalu_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_A,
  input  logic [8*NUM_REQ-1:0] req_B,
  input  logic [3*NUM_REQ-1:0] req_op,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [15:0]          rsp_result,
  output logic                 rsp_err,
  output logic [7:0]           alu_A,
  output logic [7:0]           alu_B,
  output logic [2:0]           alu_op,
  output logic                 alu_start,
  input  logic                 alu_done,
  input  logic [15:0]          alu_result,
  output logic                 busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [CW-1:0]    r_cnt;
  logic [7:0]       r_alu_A;
  logic [7:0]       r_alu_B;
  logic [2:0]       r_alu_op;
  logic             r_start;
  logic [15:0]      r_result;
  logic             r_err;

  logic [7:0]       w_a  [NUM_REQ];
  logic [7:0]       w_b  [NUM_REQ];
  logic [2:0]       w_op [NUM_REQ];
  logic [IDW-1:0]   w_cand;
  logic [IDW-1:0]   w_gnt_id;
  logic             w_gnt_found;
  logic             w_accept;
  logic             w_legal;
  logic             w_tmo_hit;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      w_a[k]  = req_A[8*k +: 8];
      w_b[k]  = req_B[8*k +: 8];
      w_op[k] = req_op[3*k +: 3];
    end
  end

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    w_cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = IDW'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_gnt_found && req_valid[w_cand]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = w_cand;
      end
    end
  end

  assign w_accept  = (r_state == S_IDLE) && w_gnt_found;
  // Legal opcodes are exactly 1..4 (add, and, xor, mul).
  assign w_legal   = (w_op[w_gnt_id] != 3'b000) && (w_op[w_gnt_id] <= 3'b100);
  // Last permitted BUSY cycle; alu_done in this same cycle still wins.
  assign w_tmo_hit = (r_cnt == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_gnt_id] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (r_state == S_RESP) rsp_valid[r_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_legal ? S_BUSY : S_RESP;
      S_BUSY:  if (alu_done || w_tmo_hit) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr    <= '0;
      r_id     <= '0;
      r_cnt    <= '0;
      r_alu_A  <= '0;
      r_alu_B  <= '0;
      r_alu_op <= '0;
      r_start  <= 1'b0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_id  <= w_gnt_id;
            r_ptr <= (w_gnt_id == IDW'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
            r_cnt <= '0;
            if (w_legal) begin
              r_alu_A  <= w_a[w_gnt_id];
              r_alu_B  <= w_b[w_gnt_id];
              r_alu_op <= w_op[w_gnt_id];
              r_start  <= 1'b1;
            end else begin
              // Illegal commands bypass the ALU and answer straight away.
              r_result <= '0;
              r_err    <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          if (alu_done) begin
            r_start  <= 1'b0;
            r_result <= alu_result;
            r_err    <= 1'b0;
          end else if (w_tmo_hit) begin
            r_start  <= 1'b0;
            r_result <= '0;
            r_err    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign alu_A      = r_alu_A;
  assign alu_B      = r_alu_B;
  assign alu_op     = r_alu_op;
  assign alu_start  = r_start;
  assign rsp_result = r_result;
  assign rsp_err    = r_err;
  assign busy       = (r_state != S_IDLE);

endmodule
